// File: rtl/rom_a_step_sequencer_pkg.sv
// Shared constants and types for the ROM step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_a_step_sequencer_pkg;

    // Width of the step index presented to the pattern ROM count input.
    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_a_step_sequencer_if.sv
// Control/status bundle between a run controller (master) and the step sequencer (slave).
// Latency: n/a (wiring only).
// Backpressure: none; controls are levels, status outputs are registered in the sequencer.
//   start/pause/clear/loop_en : controller -> sequencer
//   count/busy/tick/done      : sequencer -> controller / ROM
interface rom_a_step_sequencer_if;
    import rom_a_step_sequencer_pkg::*;

    logic              start;
    logic              pause;
    logic              clear;
    logic              loop_en;
    logic [STEP_W-1:0] count;
    logic              busy;
    logic              tick;
    logic              done;

    modport master (
        output start, pause, clear, loop_en,
        input  count, busy, tick, done
    );

    modport slave (
        input  start, pause, clear, loop_en,
        output count, busy, tick, done
    );

endinterface

// File: rtl/rom_a_step_sequencer_tick_div.sv
// Step prescaler: counts enabled clocks and flags the last clock of each DIV_COUNT period.
// Latency: term is combinational from the counter; counter wraps on the same edge term is high.
// Backpressure: en low freezes the counter in place; clr forces it to zero and wins over en.
//   clk, rst_n : clock, async active-low reset
//   clr, en    : synchronous clear, count enable
//   term       : high on the enabled cycle where the counter sits at DIV_COUNT-1
module rom_a_step_sequencer_tick_div #(
    parameter int DIV_COUNT = 50000000,
    parameter int DIV_W     = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [DIV_W-1:0] cnt;

    // Qualified by en so a frozen counter parked at DIV_COUNT-1 does not fire.
    assign term = en && (cnt == DIV_W'(DIV_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rom_a_step_sequencer.sv
// Timed step-index sequencer feeding the 7-segment pattern ROM count input (steps 0..LAST).
// Latency: count/tick/done update on the clock edge ending the DIV_COUNT-th RUN clock of a step.
// Backpressure: pause freezes prescaler and count; clear aborts to IDLE; start is edge-triggered.
//   clk, rst_n : clock, async active-low reset
//   sif        : start/pause/clear/loop_en in; count/busy/tick/done out (all registered)
module rom_a_step_sequencer
    import rom_a_step_sequencer_pkg::*;
#(
    parameter int DIV_COUNT = 50000000,
    parameter int DIV_W     = 26,
    parameter int LAST      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rom_a_step_sequencer_if.slave   sif
);

    state_t            state;
    logic [STEP_W-1:0] count_q;
    logic              start_d;
    logic              tick_q;
    logic              done_q;

    logic              start_edge;
    logic              term;
    logic              div_en;
    logic              div_clr;

    assign start_edge = sif.start & ~start_d;

    // The prescaler only runs in RUN when neither clear nor pause outranks it; outside
    // RUN/PAUSE it is held at zero so every run begins with a full-length step 0.
    assign div_en  = (state == S_RUN) & ~sif.pause & ~sif.clear;
    assign div_clr = sif.clear | (state == S_IDLE) | (state == S_DONE);

    rom_a_step_sequencer_tick_div #(
        .DIV_COUNT (DIV_COUNT),
        .DIV_W     (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .en    (div_en),
        .term  (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count_q <= '0;
            start_d <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_d <= sif.start;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            if (sif.clear) begin
                state   <= S_IDLE;
                count_q <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        count_q <= '0;
                        if (!sif.pause && start_edge) begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // start_edge is deliberately ignored here: no mid-run restart.
                        if (sif.pause) begin
                            state <= S_PAUSE;
                        end else if (term) begin
                            tick_q <= 1'b1;
                            if (count_q < STEP_W'(LAST)) begin
                                count_q <= count_q + STEP_W'(1);
                            end else if (sif.loop_en) begin
                                count_q <= '0;
                            end else begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!sif.pause) begin
                            state <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        if (!sif.pause && start_edge) begin
                            state   <= S_RUN;
                            count_q <= '0;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign sif.count = count_q;
    assign sif.busy  = (state == S_RUN) || (state == S_PAUSE);
    assign sif.tick  = tick_q;
    assign sif.done  = done_q;

endmodule

// File: tb/tb_rom_a_step_sequencer.sv
// Bench for the ROM step sequencer with a 4-clock step period and LAST=5.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_a_step_sequencer;

    logic clk;
    logic rst_n;

    rom_a_step_sequencer_if sif();

    rom_a_step_sequencer #(
        .DIV_COUNT (4),
        .DIV_W     (3),
        .LAST      (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected count value at each tick pulse, pushed when the run is launched.
    int exp_q[$];
    int done_cnt = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int k;     // clocks after the edge that registered the start edge
        int cnt;
        int busy;
        int tick;
        int done;
    } vec_t;

    vec_t tab[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard side: every tick must match the next queued count, done pulses are tallied.
    always @(posedge clk) begin
        int e;
        #1;
        if (mon_en) begin
            if (sif.done === 1'b1) done_cnt++;
            if (sif.tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_unexpected: got tick with count %0d, required no tick", sif.count);
                end else begin
                    e = exp_q.pop_front();
                    chk("tick_count", int'(sif.count), e);
                end
            end
        end
    end

    initial begin
        int cur;

        tab[0]  = '{0,  0, 1, 0, 0};
        tab[1]  = '{3,  0, 1, 0, 0};
        tab[2]  = '{4,  1, 1, 1, 0};
        tab[3]  = '{5,  1, 1, 0, 0};
        tab[4]  = '{8,  2, 1, 1, 0};
        tab[5]  = '{12, 3, 1, 1, 0};
        tab[6]  = '{16, 4, 1, 1, 0};
        tab[7]  = '{20, 5, 1, 1, 0};
        tab[8]  = '{23, 5, 1, 0, 0};
        tab[9]  = '{24, 5, 0, 1, 1};
        tab[10] = '{25, 5, 0, 0, 0};
        tab[11] = '{40, 5, 0, 0, 0};

        rst_n       = 1'b0;
        sif.start   = 1'b0;
        sif.pause   = 1'b0;
        sif.clear   = 1'b0;
        sif.loop_en = 1'b0;
        cyc(3);

        chk("reset_count", int'(sif.count), 0);
        chk("reset_busy",  int'(sif.busy),  0);
        chk("reset_tick",  int'(sif.tick),  0);
        chk("reset_done",  int'(sif.done),  0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_count", int'(sif.count), 0);
        mon_en = 1'b1;

        // One-shot run, start held high throughout (single edge => single run).
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(5);
        sif.loop_en = 1'b0;
        sif.start   = 1'b1;
        cyc(1);
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(tab[i].k - cur);
            cur = tab[i].k;
            chk($sformatf("oneshot_k%0d_count", tab[i].k), int'(sif.count), tab[i].cnt);
            chk($sformatf("oneshot_k%0d_busy",  tab[i].k), int'(sif.busy),  tab[i].busy);
            chk($sformatf("oneshot_k%0d_tick",  tab[i].k), int'(sif.tick),  tab[i].tick);
            chk($sformatf("oneshot_k%0d_done",  tab[i].k), int'(sif.done),  tab[i].done);
        end
        chk("oneshot_done_pulses", done_cnt, 1);
        chk("oneshot_queue_empty", exp_q.size(), 0);

        // Restart from DONE by toggling start, this time looping.
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
        exp_q.push_back(5); exp_q.push_back(0); exp_q.push_back(1);
        sif.start = 1'b0;
        cyc(1);
        sif.loop_en = 1'b1;
        sif.start   = 1'b1;
        cyc(1);
        chk("restart_count", int'(sif.count), 0);
        chk("restart_busy",  int'(sif.busy),  1);
        cyc(29);
        chk("loop_count",       int'(sif.count), 1);
        chk("loop_busy",        int'(sif.busy),  1);
        chk("loop_no_done",     done_cnt, 1);
        chk("loop_queue_empty", exp_q.size(), 0);
        sif.clear = 1'b1;
        cyc(1);
        sif.clear = 1'b0;
        chk("loop_clear_count", int'(sif.count), 0);
        chk("loop_clear_busy",  int'(sif.busy),  0);

        // Pause on the terminal cycle of step 2, then clear at step 4.
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
        sif.loop_en = 1'b0;
        sif.start   = 1'b0;
        cyc(1);
        sif.start = 1'b1;
        cyc(1);
        chk("pause_run_busy", int'(sif.busy), 1);
        cyc(11);
        sif.pause = 1'b1;
        cyc(1);
        chk("pause_term_count", int'(sif.count), 2);
        chk("pause_term_tick",  int'(sif.tick),  0);
        chk("pause_term_busy",  int'(sif.busy),  1);
        cyc(9);
        chk("pause_hold_count", int'(sif.count), 2);
        chk("pause_hold_busy",  int'(sif.busy),  1);
        sif.pause = 1'b0;
        sif.start = 1'b0;
        cyc(1);
        chk("resume_count", int'(sif.count), 2);
        chk("resume_tick",  int'(sif.tick),  0);
        cyc(1);
        chk("resume_adv_count", int'(sif.count), 3);
        chk("resume_adv_tick",  int'(sif.tick),  1);
        cyc(4);
        chk("pre_clear_count", int'(sif.count), 4);
        sif.clear = 1'b1;
        sif.start = 1'b1;
        cyc(1);
        sif.clear = 1'b0;
        chk("clear_count", int'(sif.count), 0);
        chk("clear_busy",  int'(sif.busy),  0);
        chk("clear_done",  int'(sif.done),  0);
        cyc(3);
        chk("clear_no_restart_busy", int'(sif.busy), 0);
        chk("clear_queue_empty", exp_q.size(), 0);

        // Fresh start edge after clear, then asynchronous reset mid-run.
        exp_q.push_back(1);
        sif.start = 1'b0;
        cyc(1);
        sif.start = 1'b1;
        cyc(1);
        chk("fresh_count", int'(sif.count), 0);
        chk("fresh_busy",  int'(sif.busy),  1);
        cyc(5);
        chk("pre_reset_count", int'(sif.count), 1);
        sif.start = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("async_reset_count", int'(sif.count), 0);
        chk("async_reset_busy",  int'(sif.busy),  0);
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        chk("post_reset_busy",  int'(sif.busy),  0);
        chk("post_reset_count", int'(sif.count), 0);
        chk("total_done_pulses", done_cnt, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_a_step_sequencer.md
Name: rom_a_step_sequencer

Overview:
Generates the 3-bit step index that drives the 7-segment pattern ROM (count input, steps 0..5; codes 6 and 7 decode to the ROM's error pattern). A clock prescaler paces the steps at a fixed rate. Start/pause/clear controls and loop/one-shot modes turn the ROM's fixed digit sequence into a timed display run. The block sits directly upstream of the ROM; its count output wires straight to the ROM's count input.

Parameters:
DIV_COUNT, 50000000, clocks per step (1 Hz at 50 MHz); legal range >= 2.
DIV_W, 26, prescaler counter width; must satisfy 2**DIV_W >= DIV_COUNT.
LAST, 5, final step index; legal range 1..5, so codes 6/7 are never emitted.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level input; an internal rising-edge detect starts or restarts a run.
pause  input  1  level input; high freezes the run.
clear  input  1  synchronous abort to IDLE.
loop_en  input  1  1 = wrap LAST->0 forever; 0 = one-shot.
count  output  3  step index to the ROM count input.
busy  output  1  high in RUN or PAUSE.
tick  output  1  one-cycle pulse on every prescaler terminal event in RUN.
done  output  1  one-cycle pulse when a one-shot run completes.

Behaviour:
- Reset (rst_n low, async): state=IDLE, count=0, prescaler=0, start_d=0, busy=0, tick=0, done=0.
- All outputs are registered; busy is decoded from the state register.
- start_edge = start & ~start_d; start_d is registered every clk.
- States: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: clear > pause > start_edge > prescaler terminal.
- clear high, any state: next state IDLE, count=0, prescaler=0. tick and done are 0 that cycle.
- IDLE: count holds 0. start_edge -> RUN with prescaler=0. Step 0 is therefore shown for a full DIV_COUNT clocks.
- RUN, prescaler advance:
  - Each clk, prescaler +1.
  - When prescaler==DIV_COUNT-1: prescaler->0 and tick=1 for one cycle, aligned with the count update.
  - If count<LAST: count+1.
  - If count==LAST and loop_en=1: count->0, stay in RUN.
  - If count==LAST and loop_en=0: ->DONE, done=1 for one cycle, count holds LAST.
- RUN, pause high: ->PAUSE. Prescaler and count freeze.
  - pause wins over a same-cycle terminal prescaler: no advance, prescaler stays at DIV_COUNT-1.
  - That advance occurs on the first RUN cycle after resume.
- PAUSE: pause low -> RUN, resuming with the frozen prescaler value. start_edge is ignored.
- RUN, start_edge: ignored (no restart mid-run).
- DONE: count holds LAST, busy=0. start_edge -> RUN with count=0, prescaler=0.
- loop_en is sampled only at the LAST terminal event, so changing it mid-run affects only the next wrap decision.
- count never exceeds LAST. Wrap is explicit, never modulo-8 overflow.
- Reset asserted mid-run: immediate return to reset values. No done pulse is emitted.

Decomposition:
- Shared header (constants file): state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_PAUSE=2'd2, S_DONE=2'd3; step width constant STEP_W=3.
- One sub-module: tick_div (prescaler).
  - Inputs: clk, rst_n, clr, en.
  - Parameters: DIV_COUNT, DIV_W.
  - Output: a one-cycle terminal pulse.
  - It is the natural split; the sequencer FSM and the count register stay in the top.

Test Plan:
- Sim uses DIV_COUNT=4, LAST=5.
- Reset then start rising edge, loop_en=0 -> count steps 0,1,2,3,4,5, each held 4 clks. tick pulses at every step change. done pulses once, 4 clks after count reaches 5. busy falls with done; count stays 5.
- loop_en=1, run 30 clks -> count sequence 0..5,0,1 with no done pulse. count never shows 6 or 7.
- pause asserted at count=2, prescaler=3 (terminal cycle), held 10 clks -> count stays 2 and busy stays 1. After release, count becomes 3 on the first cycle.
- clear asserted at count=4 together with start high -> next cycle IDLE, count=0, busy=0, no done. A later fresh start edge restarts from 0.
- Holding start high through a whole one-shot run -> exactly one run (single edge). Toggling start in DONE restarts at count=0. rst_n pulsed low mid-run -> count=0, busy=0 immediately, asynchronously.
